// File: rtl/pe_layer_sequencer.sv
// -----------------------------------------------------------------------------
// pe_layer_sequencer
//
// Purpose:
//   Sequences one neural-network layer through a single external processing
//   element (PE). On start, the layer input vector and neuron count are
//   latched. Then, for each neuron k, the sequencer:
//     1. reads weight row k and bias k from memory,
//     2. registers them as PE operands,
//     3. captures the combinational PE result,
//     4. offers the result on a valid/ready output port.
//   A one-cycle done pulse marks the end of the layer.
//
// States:
//   IDLE, RD, LD, [SETTLE], EV, OUT, DONE.
//   The current state is visible on the internal signal 'state' (type
//   state_t) for checkers.
//
// Configuration:
//   PE_SETTLE_CYCLE_EN
//     When defined, an extra SETTLE state is inserted between LD and EV.
//     This gives the PE a two-cycle multicycle path, so the minimum time
//     per neuron becomes 5 cycles instead of 4.
//
// Ports:
//   clk, rst_n              sole clock (rising edge); async active-low reset
//   start                   begin a layer (sampled only in IDLE)
//   num_neurons [NAW]       neuron count, latched on an accepted start
//   in_vec [N_IN*DW]        layer input vector, latched on an accepted start
//   busy                    high in every state except IDLE
//   done                    one-cycle pulse at layer completion
//   mem_rd, mem_addr [NAW]  memory read strobe and neuron index
//   mem_weight, mem_bias    read data, valid the cycle after mem_rd
//   pe_in, pe_weight,
//   pe_bias                 registered PE operands
//   pe_out [DW]             combinational saturated PE result
//   out_valid, out_ready    result handshake
//   out_data [DW],
//   out_idx [NAW]           result value and its neuron index
//
// Handshake:
//   A result transfers on a cycle where out_valid & out_ready are both high.
//   - out_valid depends on state only, never on out_ready.
//   - Once raised, out_valid, out_data and out_idx hold unchanged until the
//     transfer happens.
// -----------------------------------------------------------------------------
module pe_layer_sequencer #(
    parameter int N_IN = 62,
    parameter int DW   = 8,
    parameter int NAW  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NAW-1:0]       num_neurons,
    input  logic [N_IN*DW-1:0]   in_vec,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd,
    output logic [NAW-1:0]       mem_addr,
    input  logic [N_IN*DW-1:0]   mem_weight,
    input  logic [DW-1:0]        mem_bias,
    output logic [N_IN*DW-1:0]   pe_in,
    output logic [N_IN*DW-1:0]   pe_weight,
    output logic [DW-1:0]        pe_bias,
    input  logic [DW-1:0]        pe_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [NAW-1:0]       out_idx
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        LD     = 3'd2,
        SETTLE = 3'd3,
        EV     = 3'd4,
        OUT    = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [NAW-1:0] k;      // current neuron index
    logic [NAW-1:0] nn;     // latched neuron count for the running layer
    logic           last;   // current neuron is the final one of the layer

    // nn is never zero once we leave IDLE: a zero count goes straight to DONE.
    assign last = (k == nn - NAW'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (num_neurons == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RD;
                    end
                end
            end

            RD: begin
                mem_rd   = 1'b1;
                mem_addr = k;
                state_nx = LD;
            end

            LD: begin
`ifdef PE_SETTLE_CYCLE_EN
                state_nx = SETTLE;
`else
                state_nx = EV;
`endif
            end

            SETTLE: begin
                state_nx = EV;
            end

            EV: begin
                state_nx = OUT;
            end

            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RD;
                    end
                end
            end

            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // Operands are copied bit-for-bit: the PE owns the sign-magnitude
    // arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= '0;
            nn        <= '0;
            pe_in     <= '0;
            pe_weight <= '0;
            pe_bias   <= '0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pe_in <= in_vec;
                        nn    <= num_neurons;
                        k     <= '0;
                    end
                end

                LD: begin
                    pe_weight <= mem_weight;
                    pe_bias   <= mem_bias;
                end

                EV: begin
                    out_data <= pe_out;
                    out_idx  <= k;
                end

                OUT: begin
                    if (out_ready && !last) begin
                        k <= k + NAW'(1);
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_layer_sequencer.sv
`timescale 1ns/1ps
module tb_pe_layer_sequencer;

    localparam int N_IN = 62;
    localparam int DW   = 8;
    localparam int NAW  = 6;
    localparam int VW   = N_IN * DW;
    localparam int MW   = DW - 1;

`ifdef PE_SETTLE_CYCLE_EN
    localparam bit SETTLE = 1'b1;
`else
    localparam bit SETTLE = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [NAW-1:0]  num_neurons;
    logic [VW-1:0]   in_vec;
    logic            busy;
    logic            done;
    logic            mem_rd;
    logic [NAW-1:0]  mem_addr;
    logic [VW-1:0]   mem_weight;
    logic [DW-1:0]   mem_bias;
    logic [VW-1:0]   pe_in;
    logic [VW-1:0]   pe_weight;
    logic [DW-1:0]   pe_bias;
    logic [DW-1:0]   pe_out;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [NAW-1:0]  out_idx;

    always #5 clk = ~clk;

    pe_layer_sequencer #(.N_IN(N_IN), .DW(DW), .NAW(NAW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_neurons(num_neurons),
        .in_vec     (in_vec),
        .busy       (busy),
        .done       (done),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_weight (mem_weight),
        .mem_bias   (mem_bias),
        .pe_in      (pe_in),
        .pe_weight  (pe_weight),
        .pe_bias    (pe_bias),
        .pe_out     (pe_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected transfers, packed as {idx, data}.
    logic [NAW+DW-1:0] exp_q[$];

    // ------------------------------------------------------------------
    // Sign-magnitude helpers and the PE model
    // ------------------------------------------------------------------
    function automatic int sm2int(input logic [DW-1:0] v);
        int m;
        m = int'(v[DW-2:0]);
        return v[DW-1] ? -m : m;
    endfunction

    function automatic logic [DW-1:0] int2sm(input int v);
        if (v < 0) return {1'b1, MW'(-v)};
        return {1'b0, MW'(v)};
    endfunction

    // Dot product plus bias, saturated to +/-(2^(DW-1)-1).
    function automatic logic [DW-1:0] pe_model(input logic [VW-1:0] a,
                                               input logic [VW-1:0] w,
                                               input logic [DW-1:0] b);
        int acc;
        int lim;
        lim = (1 << (DW - 1)) - 1;
        acc = sm2int(b);
        for (int i = 0; i < N_IN; i++) begin
            acc += sm2int(a[i*DW +: DW]) * sm2int(w[i*DW +: DW]);
        end
        if (acc > lim)  acc = lim;
        if (acc < -lim) acc = -lim;
        return int2sm(acc);
    endfunction

    always_comb pe_out = pe_model(pe_in, pe_weight, pe_bias);

    // ------------------------------------------------------------------
    // Weight/bias memory: one cycle read latency, counts reads per row
    // ------------------------------------------------------------------
    logic [VW-1:0] rom_w [0:3];
    logic [DW-1:0] rom_b [0:3];
    int            rd_count [0:3];

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_weight <= rom_w[mem_addr[1:0]];
            mem_bias   <= rom_b[mem_addr[1:0]];
            rd_count[mem_addr[1:0]]++;
        end
    end

    task automatic clear_rd();
        for (int i = 0; i < 4; i++) rd_count[i] = 0;
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transfer monitor against the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL transfer: unexpected idx %0d data %0h", out_idx, out_data);
            end else begin
                chk("transfer", {out_idx, out_data}, exp_q.pop_front());
            end
        end
    end

    // Return at a negedge where out_valid is high, or flag a timeout.
    task automatic wait_valid(input int max_cyc, input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            @(negedge clk);
            got = out_valid;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: out_valid not seen within %0d cycles", name, max_cyc);
        end
    endtask

    // Return at a negedge where done is high, or flag a timeout.
    task automatic wait_done(input int max_cyc, input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            @(negedge clk);
            got = done;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Cycle table for the basic two-neuron layer
    // ------------------------------------------------------------------
    typedef struct {
        logic           start;
        logic           rdy;
        logic           busy;
        logic           done;
        logic           rd;
        logic [NAW-1:0] addr;
        logic           ov;
        logic [DW-1:0]  od;
        logic [NAW-1:0] oi;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic rdy, input logic bz,
                       input logic dn, input logic rd, input int addr,
                       input logic ov, input logic [DW-1:0] od, input int oi);
        vec_t v;
        v.start = st;
        v.rdy   = rdy;
        v.busy  = bz;
        v.done  = dn;
        v.rd    = rd;
        v.addr  = NAW'(addr);
        v.ov    = ov;
        v.od    = od;
        v.oi    = NAW'(oi);
        tbl.push_back(v);
    endtask

    logic [VW-1:0] vec_a;
    logic [VW-1:0] vec_b;

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int lat;
        int done_seen;
        logic [DW-1:0]  hold_d;
        logic [NAW-1:0] hold_i;

        rst_n       = 1'b0;
        start       = 1'b0;
        num_neurons = '0;
        in_vec      = '0;
        out_ready   = 1'b0;
        mem_weight  = '0;
        mem_bias    = '0;
        clear_rd();

        // Lane 4 pushes row 0 into positive saturation:
        // lanes 0..3 sum to 27, lane 4 adds 200 -> 7F.
        vec_a = '0;
        vec_a[0*DW +: DW] = int2sm(100);
        vec_a[1*DW +: DW] = int2sm(93);
        vec_a[2*DW +: DW] = int2sm(-103);
        vec_a[3*DW +: DW] = int2sm(-127);
        vec_a[4*DW +: DW] = int2sm(100);

        // Row 0 with vec_b: -5 + 100 = 95 -> 8'h5F.
        vec_b = '0;
        vec_b[0*DW +: DW] = int2sm(1);

        for (int r = 0; r < 4; r++) begin
            rom_w[r] = '0;
            rom_b[r] = '0;
        end
        rom_w[0][0*DW +: DW] = int2sm(-5);
        rom_w[0][1*DW +: DW] = int2sm(4);
        rom_w[0][2*DW +: DW] = int2sm(-3);
        rom_w[0][3*DW +: DW] = int2sm(2);
        rom_w[0][4*DW +: DW] = int2sm(2);
        rom_b[0] = int2sm(100);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {busy, done, mem_rd, mem_addr, out_valid, out_data, out_idx}, '0);
        chk("reset_pe_in", pe_in, '0);
        chk("reset_pe_w", {pe_weight, pe_bias}, '0);
        next_cycle();
        rst_n = 1'b1;

        // ---------------- table-driven two-neuron layer ----------------
        // Columns: start rdy busy done rd addr ov od oi
        add(1, 1, 0, 0, 0, 0, 0, 8'h00, 0);      // IDLE, start sampled
        add(0, 1, 1, 0, 1, 0, 0, 8'h00, 0);      // RD row 0
        add(0, 1, 1, 0, 0, 0, 0, 8'h00, 0);      // LD
        if (SETTLE) add(0, 1, 1, 0, 0, 0, 0, 8'h00, 0);
        add(0, 1, 1, 0, 0, 0, 0, 8'h00, 0);      // EV
        add(0, 1, 1, 0, 0, 0, 1, 8'h7F, 0);      // OUT neuron 0
        add(0, 1, 1, 0, 1, 1, 0, 8'h7F, 0);      // RD row 1
        add(0, 1, 1, 0, 0, 0, 0, 8'h7F, 0);      // LD
        if (SETTLE) add(0, 1, 1, 0, 0, 0, 0, 8'h7F, 0);
        add(0, 1, 1, 0, 0, 0, 0, 8'h7F, 0);      // EV
        add(0, 1, 1, 0, 0, 0, 1, 8'h00, 1);      // OUT neuron 1
        add(0, 1, 1, 1, 0, 0, 0, 8'h00, 1);      // DONE
        add(0, 1, 0, 0, 0, 0, 0, 8'h00, 1);      // IDLE

        exp_q.push_back({NAW'(0), 8'h7F});
        exp_q.push_back({NAW'(1), 8'h00});
        in_vec      = vec_a;
        num_neurons = NAW'(2);
        foreach (tbl[i]) begin
            start     = tbl[i].start;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_rd", i), mem_rd, tbl[i].rd);
            if (tbl[i].rd) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_od", i), out_data, tbl[i].od);
            chk($sformatf("tbl%0d_oi", i), out_idx, tbl[i].oi);
            next_cycle();
        end
        chk("tbl_pe_in", pe_in, vec_a);
        chk("tbl_rd0", rd_count[0], 1);
        chk("tbl_rd1", rd_count[1], 1);
        chk("tbl_q_empty", exp_q.size(), 0);

        // ---------------- back-pressure in first OUT ----------------
        clear_rd();
        exp_q.push_back({NAW'(0), 8'h7F});
        exp_q.push_back({NAW'(1), 8'h00});
        out_ready = 1'b0;
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_valid(20, "stall_valid");
        hold_d = out_data;
        hold_i = out_idx;
        chk("stall_first_d", hold_d, 8'h7F);
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("stall%0d", c), {out_valid, out_idx, out_data}, {1'b1, NAW'(0), 8'h7F});
        end
        next_cycle();
        out_ready = 1'b1;
        wait_done(20, "stall_done");
        next_cycle();
        chk("stall_rd0", rd_count[0], 1);
        chk("stall_rd1", rd_count[1], 1);
        chk("stall_q_empty", exp_q.size(), 0);

        // ---------------- start while busy is ignored ----------------
        exp_q.push_back({NAW'(0), 8'h7F});
        exp_q.push_back({NAW'(1), 8'h00});
        start = 1'b1;
        next_cycle();
        in_vec      = vec_b;
        num_neurons = NAW'(1);
        repeat (5) next_cycle();             // start held high while busy
        start = 1'b0;
        wait_done(20, "busy_done");
        next_cycle();
        chk("busy_idle", busy, 1'b0);
        chk("busy_pe_in", pe_in, vec_a);
        chk("busy_q_empty", exp_q.size(), 0);
        in_vec      = vec_a;
        num_neurons = NAW'(2);

        // ---------------- zero-neuron layer ----------------
        clear_rd();
        num_neurons = '0;
        start       = 1'b1;
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", {busy, done, mem_rd}, 3'b110);
        next_cycle();
        @(negedge clk);
        chk("zero_after", {busy, done, mem_rd}, 3'b000);
        chk("zero_reads", rd_count[0] + rd_count[1], 0);
        next_cycle();

        // ---------------- first-result latency, one neuron ----------------
        exp_q.push_back({NAW'(0), 8'h7F});
        num_neurons = NAW'(1);
        start       = 1'b1;
        @(negedge clk);
        next_cycle();
        start = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (out_valid) lat = c;
            else next_cycle();
        end
        chk("latency", lat, SETTLE ? 5 : 4);
        wait_done(10, "lat_done");
        next_cycle();
        chk("lat_q_empty", exp_q.size(), 0);

        // ---------------- reset in the middle of OUT ----------------
        num_neurons = NAW'(2);
        out_ready   = 1'b0;
        start       = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_valid(20, "rst_valid");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_now_ctrl", {busy, done, mem_rd, mem_addr, out_valid, out_data, out_idx}, '0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_edge_ctrl", {busy, done, mem_rd, mem_addr, out_valid, out_data, out_idx}, '0);
        chk("rst_pe_in", pe_in, '0);
        chk("rst_pe_w", {pe_weight, pe_bias}, '0);
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
            next_cycle();
        end
        chk("rst_no_done", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
